// File: rtl/iob_spi_fl_seq_pkg.sv
// Shared definitions for the SPI flash operation sequencer.
// Holds the flash opcodes, the core transaction-type encodings and the request
// operation codes. It also holds the FSM state types and the step descriptor
// (opcode, nmiso, commtype) that is handed to the single-transaction issuer.
package iob_spi_fl_seq_pkg;

    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_PP   = 8'h02;
    localparam logic [7:0] OPC_SE   = 8'h20;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    localparam int SR_WIP = 0;

    typedef enum logic [2:0] {
        CMD_ONLY    = 3'd0,
        CMD_RD      = 3'd1,
        CMD_ADDR    = 3'd2,
        CMD_ADDR_WR = 3'd3,
        CMD_ADDR_RD = 3'd4
    } commtype_t;

    typedef enum logic [1:0] {
        REQ_READ    = 2'd0,
        REQ_PROGRAM = 2'd1,
        REQ_ERASE   = 2'd2,
        REQ_STATUS  = 2'd3
    } req_op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_MAIN, S_POLL, S_GAP, S_RESP
    } seq_state_t;

    typedef enum logic [1:0] {
        X_IDLE, X_ISSUE, X_WAIT
    } xfer_state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [6:0] nmiso;
        commtype_t  commtype;
    } step_t;

    localparam step_t WREN_STEP = '{opcode: OPC_WREN, nmiso: 7'd0, commtype: CMD_ONLY};
    localparam step_t RDSR_STEP = '{opcode: OPC_RDSR, nmiso: 7'd8, commtype: CMD_RD};

    // Program and erase modify the array, so they must be preceded by WREN
    // and followed by status polling.
    function automatic logic is_write_op(input req_op_t op);
        return (op == REQ_PROGRAM) || (op == REQ_ERASE);
    endfunction

    function automatic step_t main_step(input req_op_t op);
        step_t s;
        case (op)
            REQ_READ:    s = '{opcode: OPC_READ, nmiso: 7'd32, commtype: CMD_ADDR_RD};
            REQ_PROGRAM: s = '{opcode: OPC_PP,   nmiso: 7'd0,  commtype: CMD_ADDR_WR};
            REQ_ERASE:   s = '{opcode: OPC_SE,   nmiso: 7'd0,  commtype: CMD_ADDR};
            default:     s = RDSR_STEP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/iob_spi_fl_seq_if.sv
// Bus bundle between the CPU-side request/response channel, the sequencer and
// the spi_master_fl core.
//   slave  : the sequencer's view (takes requests, drives the core inputs)
//   master : the environment's view (issues requests, models the core)
interface iob_spi_fl_seq_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [7:0]        fl_command;
    logic [6:0]        fl_nmiso_bits;
    logic [ADDR_W-1:0] fl_address;
    logic [DATA_W-1:0] fl_datain;
    logic [2:0]        fl_commtype;
    logic              fl_validflag;
    logic [DATA_W-1:0] fl_dataout;
    logic              fl_validflag_out;
    logic              fl_tready;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
               fl_dataout, fl_validflag_out, fl_tready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               fl_command, fl_nmiso_bits, fl_address, fl_datain, fl_commtype, fl_validflag
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
               fl_dataout, fl_validflag_out, fl_tready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               fl_command, fl_nmiso_bits, fl_address, fl_datain, fl_commtype, fl_validflag
    );
endinterface

// File: rtl/iob_spi_fl_seq_xfer.sv
// Single-transaction issuer for spi_master_fl.
// A start pulse latches the step fields onto the fl_* outputs. It then waits
// for fl_tready, pulses fl_validflag for one cycle, and waits for
// fl_validflag_out. done is asserted in that completion cycle with rdata =
// fl_dataout, so the caller can act on the data at the same clock edge.
// Ports: clk, rst, start/step/addr/wdata (request), idle/done/rdata (status),
//        fl_* (core side).
module iob_spi_fl_seq_xfer
    import iob_spi_fl_seq_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  step_t             step,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        fl_command,
    output logic [6:0]        fl_nmiso_bits,
    output logic [ADDR_W-1:0] fl_address,
    output logic [DATA_W-1:0] fl_datain,
    output logic [2:0]        fl_commtype,
    output logic              fl_validflag,
    input  logic [DATA_W-1:0] fl_dataout,
    input  logic              fl_validflag_out,
    input  logic              fl_tready
);
    xfer_state_t       state_reg, state_next;
    logic              fire;
    logic [7:0]        command_reg;
    logic [6:0]        nmiso_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [DATA_W-1:0] datain_reg;
    logic [2:0]        commtype_reg;
    logic              validflag_reg;

    // fire selects the cycles in which the strobe is registered. That is only
    // when the core reports idle, so the strobe lands while tready is still high.
    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        case (state_reg)
            X_IDLE: begin
                if (start) begin
                    fire       = fl_tready;
                    state_next = fl_tready ? X_WAIT : X_ISSUE;
                end
            end
            X_ISSUE: begin
                if (fl_tready) begin
                    fire       = 1'b1;
                    state_next = X_WAIT;
                end
            end
            X_WAIT: begin
                if (fl_validflag_out) state_next = X_IDLE;
            end
            default: state_next = X_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= X_IDLE;
            validflag_reg <= 1'b0;
            command_reg   <= '0;
            nmiso_reg     <= '0;
            address_reg   <= '0;
            datain_reg    <= '0;
            commtype_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            validflag_reg <= fire;
            if (state_reg == X_IDLE && start) begin
                command_reg  <= step.opcode;
                nmiso_reg    <= step.nmiso;
                commtype_reg <= step.commtype;
                address_reg  <= addr;
                datain_reg   <= wdata;
            end
        end
    end

    assign idle          = (state_reg == X_IDLE);
    assign done          = (state_reg == X_WAIT) && fl_validflag_out;
    assign rdata         = fl_dataout;
    assign fl_command    = command_reg;
    assign fl_nmiso_bits = nmiso_reg;
    assign fl_address    = address_reg;
    assign fl_datain     = datain_reg;
    assign fl_commtype   = commtype_reg;
    assign fl_validflag  = validflag_reg;
endmodule

// File: rtl/iob_spi_fl_seq.sv
// Operation sequencer in front of spi_master_fl.
// It expands one request (READ / PROGRAM / ERASE / STATUS) into the core
// command sequence. Write operations use WREN, the main command, and then
// RDSR polls spaced POLL_GAP cycles apart until WIP clears. After POLL_MAX
// polls the operation gives up and reports an error. The result is held on
// rsp_* until it is consumed.
// Ports: clk, rst (async, active-high), bus (request, response and core
// signals; see iob_spi_fl_seq_if).
module iob_spi_fl_seq
    import iob_spi_fl_seq_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int POLL_GAP = 64,
    parameter int POLL_MAX = 65535
) (
    input  logic              clk,
    input  logic              rst,
    iob_spi_fl_seq_if.slave   bus
);
    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam int GCNT_W = $clog2(POLL_GAP + 1);

    seq_state_t        state_reg, state_next;
    req_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [PCNT_W-1:0] poll_cnt_reg;
    logic [GCNT_W-1:0] gap_cnt_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    step_t             step;
    logic              x_start, x_idle, x_done;
    logic [DATA_W-1:0] x_rdata;
    logic [7:0]        sr;
    logic              sr_busy;
    logic              poll_last;
    logic              gap_last;

    assign sr        = x_rdata[7:0];
    assign sr_busy   = sr[SR_WIP];
    // The poll finishing now is the POLL_MAX-th one.
    assign poll_last = (poll_cnt_reg == PCNT_W'(POLL_MAX - 1));
    assign gap_last  = (gap_cnt_reg == GCNT_W'(POLL_GAP - 1));

    always_comb begin
        state_next = state_reg;
        step       = RDSR_STEP;
        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid)
                    state_next = is_write_op(req_op_t'(bus.req_op)) ? S_WREN : S_MAIN;
            end
            S_WREN: begin
                step = WREN_STEP;
                if (x_done) state_next = S_MAIN;
            end
            S_MAIN: begin
                step = main_step(op_reg);
                if (x_done) state_next = is_write_op(op_reg) ? S_POLL : S_RESP;
            end
            S_POLL: begin
                if (x_done) state_next = (!sr_busy || poll_last) ? S_RESP : S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_next = S_POLL;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Each step state launches the issuer once: on completion the state always
    // advances, so an idle issuer inside a step state means "not yet started".
    assign x_start = (state_reg == S_WREN || state_reg == S_MAIN || state_reg == S_POLL) && x_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= REQ_READ;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            poll_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && bus.req_valid) begin
                op_reg       <= req_op_t'(bus.req_op);
                addr_reg     <= bus.req_addr;
                wdata_reg    <= bus.req_wdata;
                poll_cnt_reg <= '0;
            end
            if (state_reg == S_POLL && x_done && poll_cnt_reg != PCNT_W'(POLL_MAX))
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
            gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + 1'b1 : '0;
            // Response payload is captured on the edge that enters RESP.
            if (state_reg == S_MAIN && x_done && op_reg == REQ_READ) begin
                rsp_rdata_reg <= x_rdata;
                rsp_err_reg   <= 1'b0;
            end
            if (state_reg == S_MAIN && x_done && op_reg == REQ_STATUS) begin
                rsp_rdata_reg <= {{(DATA_W-8){1'b0}}, sr};
                rsp_err_reg   <= 1'b0;
            end
            if (state_reg == S_POLL && x_done && !sr_busy) begin
                rsp_rdata_reg <= '0;
                rsp_err_reg   <= 1'b0;
            end
            if (state_reg == S_POLL && x_done && sr_busy && poll_last) begin
                rsp_rdata_reg <= {{(DATA_W-8){1'b0}}, sr};
                rsp_err_reg   <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.rsp_valid = (state_reg == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    iob_spi_fl_seq_xfer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_xfer (
        .clk              (clk),
        .rst              (rst),
        .start            (x_start),
        .step             (step),
        .addr             (addr_reg),
        .wdata            (wdata_reg),
        .idle             (x_idle),
        .done             (x_done),
        .rdata            (x_rdata),
        .fl_command       (bus.fl_command),
        .fl_nmiso_bits    (bus.fl_nmiso_bits),
        .fl_address       (bus.fl_address),
        .fl_datain        (bus.fl_datain),
        .fl_commtype      (bus.fl_commtype),
        .fl_validflag     (bus.fl_validflag),
        .fl_dataout       (bus.fl_dataout),
        .fl_validflag_out (bus.fl_validflag_out),
        .fl_tready        (bus.fl_tready)
    );
endmodule

// File: tb/tb_iob_spi_fl_seq.sv
// Bench for iob_spi_fl_seq. A small flash-core model answers transactions.
// A request-level model lists the core transactions and the response each
// request must produce. A negedge compare process checks every issued
// transaction and every response against those lists.
module tb_iob_spi_fl_seq;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int POLL_GAP = 8;
    localparam int POLL_MAX = 4;
    localparam int CORE_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_spi_fl_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_spi_fl_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        total_cnt++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- flash core model ----------------
    logic        force_busy = 1'b0;
    int          wip_polls  = 0;
    logic [7:0]  sr_idle    = 8'h00;
    logic [31:0] read_data  = 32'h0;
    logic        core_busy;
    int          core_cnt;
    logic [7:0]  core_cmd;
    int          rdsr_since_wren;

    assign bus.fl_tready = !core_busy && !force_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy            <= 1'b0;
            core_cnt             <= 0;
            core_cmd             <= 8'h00;
            rdsr_since_wren      <= 0;
            bus.fl_validflag_out <= 1'b0;
            bus.fl_dataout       <= '0;
        end else begin
            bus.fl_validflag_out <= 1'b0;
            if (!core_busy && bus.fl_validflag) begin
                core_busy <= 1'b1;
                core_cnt  <= CORE_LAT;
                core_cmd  <= bus.fl_command;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    core_busy            <= 1'b0;
                    bus.fl_validflag_out <= 1'b1;
                    case (core_cmd)
                        8'h03: bus.fl_dataout <= read_data;
                        8'h05: begin
                            // upper bits are junk the sequencer must discard
                            bus.fl_dataout  <= (rdsr_since_wren < wip_polls) ? 32'hA5A5A501
                                                                             : {24'hA5A5A5, sr_idle};
                            rdsr_since_wren <= rdsr_since_wren + 1;
                        end
                        8'h06: begin
                            bus.fl_dataout  <= 32'h0;
                            rdsr_since_wren <= 0;
                        end
                        default: bus.fl_dataout <= 32'h0;
                    endcase
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    // ---------------- request-level model ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [2:0]  ctype;
        logic [6:0]  nmiso;
        logic [23:0] addr;
        logic [31:0] data;
        bit          chk_addr;
        bit          chk_data;
    } txn_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    txn_t exp_txn[$];
    rsp_t exp_rsp[$];

    function automatic txn_t mk(input logic [7:0] c, input logic [2:0] ct, input logic [6:0] nm,
                                input logic [23:0] a, input logic [31:0] d, input bit ca, input bit cd);
        txn_t t;
        t.cmd = c; t.ctype = ct; t.nmiso = nm; t.addr = a; t.data = d;
        t.chk_addr = ca; t.chk_data = cd;
        return t;
    endfunction

    task automatic model_push(input int op, input logic [23:0] a, input logic [31:0] d);
        rsp_t r;
        int   n;
        case (op)
            0: begin
                exp_txn.push_back(mk(8'h03, 3'd4, 7'd32, a, 32'h0, 1'b1, 1'b0));
                r.rdata = read_data; r.err = 1'b0;
            end
            3: begin
                exp_txn.push_back(mk(8'h05, 3'd1, 7'd8, 24'h0, 32'h0, 1'b0, 1'b0));
                r.rdata = {24'h0, sr_idle}; r.err = 1'b0;
            end
            default: begin
                exp_txn.push_back(mk(8'h06, 3'd0, 7'd0, 24'h0, 32'h0, 1'b0, 1'b0));
                if (op == 1) exp_txn.push_back(mk(8'h02, 3'd3, 7'd0, a, d, 1'b1, 1'b1));
                else         exp_txn.push_back(mk(8'h20, 3'd2, 7'd0, a, 32'h0, 1'b1, 1'b0));
                n = (wip_polls < POLL_MAX) ? wip_polls + 1 : POLL_MAX;
                for (int i = 0; i < n; i++)
                    exp_txn.push_back(mk(8'h05, 3'd1, 7'd8, 24'h0, 32'h0, 1'b0, 1'b0));
                r.err   = (wip_polls >= POLL_MAX);
                r.rdata = r.err ? 32'h1 : 32'h0;
            end
        endcase
        exp_rsp.push_back(r);
    endtask

    // ---------------- compare process ----------------
    int          cyc = 0;
    int          vf_count = 0;
    int          rsp_count = 0;
    int          last_rdsr_cyc = 0;
    logic [7:0]  prev_cmd = 8'h00;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        txn_t t;
        rsp_t r;
        cyc++;
        if (rst) begin
            prev_cmd = 8'h00;
        end else begin
            if (bus.fl_validflag) begin
                vf_count++;
                chk("vf_tready", bus.fl_tready, 1'b1);
                if (exp_txn.size() == 0) begin
                    fail_now("txn_unexpected", $sformatf("got cmd %02h, required no transaction", bus.fl_command));
                end else begin
                    t = exp_txn.pop_front();
                    chk("txn_cmd", bus.fl_command, t.cmd);
                    chk("txn_commtype", bus.fl_commtype, t.ctype);
                    chk("txn_nmiso", bus.fl_nmiso_bits, t.nmiso);
                    if (t.chk_addr) chk("txn_addr", bus.fl_address, t.addr);
                    if (t.chk_data) chk("txn_data", bus.fl_datain, t.data);
                end
                if (bus.fl_command == 8'h05 && prev_cmd == 8'h05)
                    chk("poll_gap", (cyc - last_rdsr_cyc) >= POLL_GAP, 1'b1);
                if (bus.fl_command == 8'h05) last_rdsr_cyc = cyc;
                prev_cmd = bus.fl_command;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                $display("rsp %0d: rdata=%08h err=%0d", rsp_count, bus.rsp_rdata, bus.rsp_err);
                if (exp_rsp.size() == 0) begin
                    fail_now("rsp_unexpected", $sformatf("got rdata %08h, required no response", bus.rsp_rdata));
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                    chk("rsp_err", bus.rsp_err, r.err);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input logic [23:0] a, input logic [31:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 500) begin tick(); n++; end
        if (n >= 500) fail_now("accept_timeout", "req_ready never rose");
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_count < target && n < 3000) begin tick(); n++; end
        if (n >= 3000) fail_now("rsp_timeout", $sformatf("responses %0d, required %0d", rsp_count, target));
        tick();
    endtask

    initial begin
        int base;
        int bad;
        int n;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_fl_validflag", bus.fl_validflag, 1'b0);
        chk("rst_fl_command", bus.fl_command, 8'h00);
        chk("rst_fl_commtype", bus.fl_commtype, 3'd0);
        chk("rst_fl_address", bus.fl_address, 24'h0);

        // READ
        read_data = 32'hDEADBEEF;
        model_push(0, 24'h001000, 32'h0);
        base = vf_count;
        send(0, 24'h001000, 32'h0);
        wait_rsp(1);
        chk("read_txn_count", vf_count - base, 1);
        chk("read_rdata_lit", last_rdata, 32'hDEADBEEF);
        chk("read_err_lit", last_err, 1'b0);

        // PROGRAM, WIP for 3 polls
        wip_polls = 3;
        model_push(1, 24'h000100, 32'h12345678);
        base = vf_count;
        send(1, 24'h000100, 32'h12345678);
        wait_rsp(2);
        chk("prog_txn_count", vf_count - base, 6);
        chk("prog_err_lit", last_err, 1'b0);

        // ERASE, WIP stuck -> timeout after POLL_MAX polls
        wip_polls = 100;
        model_push(2, 24'h020000, 32'h0);
        base = vf_count;
        send(2, 24'h020000, 32'h0);
        wait_rsp(3);
        chk("erase_txn_count", vf_count - base, 6);
        chk("erase_err_lit", last_err, 1'b1);
        chk("erase_rdata_lit", last_rdata, 32'h1);

        // STATUS
        wip_polls = 0;
        sr_idle   = 8'h4C;
        model_push(3, 24'hABCDEF, 32'h0);
        send(3, 24'hABCDEF, 32'h0);
        wait_rsp(4);
        chk("status_rdata_lit", last_rdata, 32'h0000004C);

        // core not ready for 20 cycles after accept
        force_busy = 1'b1;
        read_data  = 32'hCAFEF00D;
        model_push(0, 24'h0A0B0C, 32'h0);
        base = vf_count;
        send(0, 24'h0A0B0C, 32'h0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fl_validflag) bad++;
            tick();
        end
        chk("busy_no_validflag", bad, 0);
        force_busy = 1'b0;
        wait_rsp(5);
        chk("busy_one_pulse", vf_count - base, 1);

        // response held for 10 cycles with a second request waiting
        bus.rsp_ready = 1'b0;
        read_data     = 32'h55AA33CC;
        model_push(0, 24'h000200, 32'h0);
        send(0, 24'h000200, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 500) begin tick(); n++; end
        chk("hold_rsp_arrived", bus.rsp_valid, 1'b1);
        model_push(0, 24'h000300, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_addr  = 24'h000300;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.rsp_valid || bus.rsp_rdata !== 32'h55AA33CC || bus.req_ready) bad++;
            tick();
        end
        chk("hold_stable", bad, 0);
        bus.rsp_ready = 1'b1;
        tick();
        chk("hold_retired", rsp_count, 6);
        chk("hold_rsp_valid_low", bus.rsp_valid, 1'b0);
        chk("hold_req_ready_rise", bus.req_ready, 1'b1);
        tick();
        chk("hold_second_accepted", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        wait_rsp(7);
        chk("hold_second_rdata", last_rdata, 32'h55AA33CC);

        // reset while waiting between polls
        wip_polls = 100;
        model_push(1, 24'h000400, 32'hA1B2C3D4);
        base = vf_count;
        send(1, 24'h000400, 32'hA1B2C3D4);
        n = 0;
        while (vf_count < base + 3 && n < 500) begin tick(); n++; end
        chk("gap_first_poll_seen", vf_count - base, 3);
        repeat (CORE_LAT + 3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req_ready", bus.req_ready, 1'b1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_validflag", bus.fl_validflag, 1'b0);
        chk("mid_rst_command", bus.fl_command, 8'h00);
        chk("mid_rst_address", bus.fl_address, 24'h0);
        exp_txn.delete();
        exp_rsp.delete();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_no_rsp", rsp_count, 7);
        read_data = 32'h0BADF00D;
        model_push(0, 24'h003000, 32'h0);
        send(0, 24'h003000, 32'h0);
        wait_rsp(8);
        chk("post_rst_rdata", last_rdata, 32'h0BADF00D);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
